sdram_read_arbiter: RTL and testbench
=====================================

// Module: sdram_read_arbiter
// PURPOSE
//  Shares the single SDRAM read-command engine between two read clients
//  (r0 = display line fetch, r1 = asset loader). Schedules periodic auto-refresh.
//  Sits between the clients and the SDRAM command/PHY block.
//  Issues one burst-read or refresh command at a time and routes returned beats to the owning client.
// PARAMETERS
//  ADDR_W          24    client/command word address width
//  DATA_W          16    SDRAM data width
//  BURST_LEN       2     beats returned per read command
//  REFRESH_PERIOD  1100  ck143 cycles between refresh requests (<=7.8us @143MHz)
//  TRFC            10    cycles held in REFRESH_WAIT after refresh accepted
// PORTS
//  ck143           in   1       system/SDRAM clock, all logic on posedge
//  reset           in   1       asynchronous, active-high reset
//  r0_req          in   1       client0 read request, held until r0_gnt
//  r0_addr         in   ADDR_W  client0 burst start address, stable while r0_req
//  r0_gnt          out  1       1-cycle pulse: client0 command accepted by engine
//  r0_valid        out  1       client0 data beat valid
//  r0_data         out  DATA_W  client0 data beat
//  r1_req/r1_addr/r1_gnt/r1_valid/r1_data  same as r0 for client1
//  cmd_valid       out  1       command to SDRAM engine valid
//  cmd_refresh     out  1       1=auto-refresh, 0=burst read (qualified by cmd_valid)
//  cmd_addr        out  ADDR_W  read start address (0 during refresh)
//  cmd_ready       in   1       engine accepts command when cmd_valid&&cmd_ready
//  rd_valid        in   1       engine read beat valid
//  rd_data         in   DATA_W  engine read beat
//  busy            out  1       FSM not in IDLE
//  refresh_overrun out  1       sticky: refresh period expired while refresh already pending
// BEHAVIOUR
//  Reset: all outputs 0.
//   FSM=IDLE, rr_last=1 (client0 wins first tie).
//   Refresh counter loaded with REFRESH_PERIOD-1, refresh_pending=0.
//  Reset mid-operation: abandons in-flight burst; late rd_valid beats after reset are dropped.
//  States: IDLE, ISSUE, WAIT_DATA, REFRESH, REFRESH_WAIT.
//  IDLE: priority refresh_pending > round-robin clients.
//   Refresh pending -> REFRESH.
//   Else if any req -> latch winner id + addr, ->ISSUE next cycle.
//   Round-robin: both req -> winner = ~rr_last. Single req -> that client.
//  ISSUE: cmd_valid=1, cmd_refresh=0, cmd_addr=latched addr.
//   Held stable until cmd_ready.
//   On accept: rN_gnt pulses same cycle, rr_last<=winner, beat_cnt<=0, ->WAIT_DATA.
//  WAIT_DATA: each rd_valid copies rd_data to winner's rN_data and pulses rN_valid.
//   1-cycle registered latency; other client's valid stays 0.
//   After BURST_LEN beats -> IDLE. No beat timeout; engine guarantees return.
//  REFRESH: cmd_valid=1, cmd_refresh=1, cmd_addr=0.
//   On accept: refresh_pending<=0, wait_cnt<=TRFC-1, ->REFRESH_WAIT.
//  REFRESH_WAIT: decrement wait_cnt; at 0 -> IDLE.
//  Refresh never preempts ISSUE/WAIT_DATA; it waits for IDLE.
//  Refresh counter is free-running, independent of FSM.
//   At 0: reload REFRESH_PERIOD-1, set refresh_pending.
//   If already pending: also set refresh_overrun (cleared only by reset).
//  Expiry same cycle as refresh accept: set wins, refresh_pending stays 1.
//  rd_valid outside WAIT_DATA: dropped, no output change.
//  Widths: beat_cnt $clog2(BURST_LEN+1), wait_cnt $clog2(TRFC+1),
//   refresh counter $clog2(REFRESH_PERIOD); no wrap except defined reload.
//  A client that drops req before gnt is a protocol violation (behaviour undefined).
// STRUCTURE
//  Shared package sdram_pkg: arb_state_t enum, client id type, BURST_LEN/TRFC/REFRESH_PERIOD defaults.
//  Sub-module sdram_refresh_timer: down-counter + pending/overrun flags, clear input from FSM.
// TESTING
//  1 r0_req only, addr 0x000010, cmd_ready=1 -> cmd_addr=0x000010, r0_gnt 1 pulse.
//    Beats 0xAAAA,0xBBBB -> r0_valid x2 with those data, r1_valid never.
//  2 r0,r1 req held together for 4 bursts -> grant order r0,r1,r0,r1.
//  3 cmd_ready low 5 cycles during ISSUE -> cmd_valid/cmd_addr stable 5 cycles.
//    gnt only on the accept cycle.
//  4 REFRESH_PERIOD=50, r1 streaming -> refresh issued at first IDLE after expiry.
//    No grants during TRFC=10 wait.
//  5 hold cmd_ready=0 in REFRESH across 2 expiries -> refresh_overrun=1.
//    Stays 1 until reset.
//  6 assert reset mid WAIT_DATA after 1 beat -> outputs 0, FSM IDLE.
//    Following rd_valid beat is dropped.

Source files
------------

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared types and defaults for the SDRAM read arbiter
//
// Purpose: FSM state enum, client id type, parameter defaults and the
//          round-robin pick helper shared by the arbiter and its refresh timer.
// Ports:   none (package).
package sdram_pkg;

  localparam int unsigned BURST_LEN_DEF      = 2;
  localparam int unsigned TRFC_DEF           = 10;
  localparam int unsigned REFRESH_PERIOD_DEF = 1100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DATA,
    ST_REFRESH,
    ST_REFRESH_WAIT
  } arb_state_t;

  typedef enum logic {
    CLIENT_0 = 1'b0,
    CLIENT_1 = 1'b1
  } client_id_t;

  // Two requesters: the one not served last wins. A lone requester always wins.
  function automatic client_id_t rr_pick(input logic req0, input logic req1,
                                         input client_id_t last);
    if (req0 && req1) begin
      return client_id_t'(~last);
    end else if (req1) begin
      return CLIENT_1;
    end else begin
      return CLIENT_0;
    end
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// rtl/sdram_refresh_timer.sv - free-running auto-refresh interval timer
//
// Purpose: counts down REFRESH_PERIOD cycles, then raises a sticky request
//          flag until the arbiter reports the refresh accepted. Flags an
//          overrun when an interval expires while a request is still open.
// Ports:
//   ck143    in   clock, all logic on posedge
//   reset    in   asynchronous active-high reset
//   clear    in   refresh command accepted this cycle
//   pending  out  refresh request outstanding
//   overrun  out  sticky, interval expired while pending (cleared by reset only)
module sdram_refresh_timer
  import sdram_pkg::*;
#(
  parameter int unsigned REFRESH_PERIOD = REFRESH_PERIOD_DEF
) (
  input  logic ck143,
  input  logic reset,
  input  logic clear,
  output logic pending,
  output logic overrun
);

  localparam int unsigned     CNT_W  = $clog2(REFRESH_PERIOD);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             expire;

  assign expire = (cnt == '0);

  // The counter never stops for the FSM; expiry beats a simultaneous clear
  // so that a fresh interval is never lost.
  always_ff @(posedge ck143 or posedge reset) begin
    if (reset) begin
      cnt     <= RELOAD;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (expire) begin
        cnt     <= RELOAD;
        pending <= 1'b1;
        if (pending) begin
          overrun <= 1'b1;
        end
      end else begin
        cnt <= cnt - CNT_W'(1);
        if (clear) begin
          pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_read_arbiter.sv
// rtl/sdram_read_arbiter.sv - two-client SDRAM burst-read arbiter with refresh
//
// Purpose: shares one SDRAM read-command engine between the display line
//          fetch (r0) and the asset loader (r1), inserts periodic
//          auto-refresh, issues one command at a time and steers returned
//          beats to the owning client.
// Ports:
//   ck143, reset             clock; asynchronous active-high reset
//   rN_req / rN_addr         client read request (held until gnt) and burst address
//   rN_gnt                   1-cycle pulse on command acceptance
//   rN_valid / rN_data       returned beat for client N (registered)
//   cmd_valid / cmd_refresh  command to engine; refresh=1 auto-refresh, 0 read
//   cmd_addr / cmd_ready     read start address (0 for refresh); engine accept
//   rd_valid / rd_data       beat from engine
//   busy                     FSM not idle
//   refresh_overrun          sticky refresh interval overrun
module sdram_read_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W         = 24,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned BURST_LEN      = BURST_LEN_DEF,
  parameter int unsigned REFRESH_PERIOD = REFRESH_PERIOD_DEF,
  parameter int unsigned TRFC           = TRFC_DEF
) (
  input  logic              ck143,
  input  logic              reset,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  output logic              r0_gnt,
  output logic              r0_valid,
  output logic [DATA_W-1:0] r0_data,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic              r1_gnt,
  output logic              r1_valid,
  output logic [DATA_W-1:0] r1_data,
  output logic              cmd_valid,
  output logic              cmd_refresh,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_ready,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              refresh_overrun
);

  localparam int unsigned      BEAT_W    = $clog2(BURST_LEN + 1);
  localparam int unsigned      WAIT_W    = $clog2(TRFC + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(TRFC - 1);

  arb_state_t        state;
  client_id_t        winner;
  client_id_t        rr_last;
  client_id_t        pick;
  logic [ADDR_W-1:0] addr_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              refresh_pending;
  logic              refresh_clear;

  assign pick = rr_pick(r0_req, r1_req, rr_last);

  // Command outputs decode straight from the state register, so they hold
  // steady through any number of cmd_ready stall cycles. Grants must pulse in
  // the accept cycle itself, hence the direct use of cmd_ready.
  assign cmd_valid     = (state == ST_ISSUE) || (state == ST_REFRESH);
  assign cmd_refresh   = (state == ST_REFRESH);
  assign cmd_addr      = (state == ST_ISSUE) ? addr_q : '0;
  assign r0_gnt        = (state == ST_ISSUE) && cmd_ready && (winner == CLIENT_0);
  assign r1_gnt        = (state == ST_ISSUE) && cmd_ready && (winner == CLIENT_1);
  assign busy          = (state != ST_IDLE);
  assign refresh_clear = (state == ST_REFRESH) && cmd_ready;

  sdram_refresh_timer #(
    .REFRESH_PERIOD(REFRESH_PERIOD)
  ) u_refresh_timer (
    .ck143  (ck143),
    .reset  (reset),
    .clear  (refresh_clear),
    .pending(refresh_pending),
    .overrun(refresh_overrun)
  );

  always_ff @(posedge ck143 or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      winner   <= CLIENT_0;
      rr_last  <= CLIENT_1;  // makes client0 the first tie winner
      addr_q   <= '0;
      beat_cnt <= '0;
      wait_cnt <= '0;
      r0_valid <= 1'b0;
      r1_valid <= 1'b0;
      r0_data  <= '0;
      r1_data  <= '0;
    end else begin
      r0_valid <= 1'b0;
      r1_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (refresh_pending) begin
            state <= ST_REFRESH;
          end else if (r0_req || r1_req) begin
            winner <= pick;
            addr_q <= (pick == CLIENT_1) ? r1_addr : r0_addr;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            rr_last  <= winner;
            beat_cnt <= '0;
            state    <= ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          // Beats outside this state are ignored, which also discards stale
          // beats from a burst abandoned by reset.
          if (rd_valid) begin
            if (winner == CLIENT_0) begin
              r0_data  <= rd_data;
              r0_valid <= 1'b1;
            end else begin
              r1_data  <= rd_data;
              r1_valid <= 1'b1;
            end
            if (beat_cnt == LAST_BEAT) begin
              state <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        ST_REFRESH: begin
          if (cmd_ready) begin
            wait_cnt <= WAIT_INIT;
            state    <= ST_REFRESH_WAIT;
          end
        end
        ST_REFRESH_WAIT: begin
          if (wait_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// tb/tb_sdram_read_arbiter.sv - self-checking bench for sdram_read_arbiter
module tb_sdram_read_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BL = 2;
  localparam int RP = 50;
  localparam int TR = 10;

  logic          ck143 = 1'b0;
  logic          reset = 1'b1;
  logic          r0_req = 1'b0, r1_req = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic          r0_gnt, r1_gnt, r0_valid, r1_valid;
  logic [DW-1:0] r0_data, r1_data;
  logic          cmd_valid, cmd_refresh;
  logic [AW-1:0] cmd_addr;
  logic          cmd_ready = 1'b0;
  logic          rd_valid = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          busy, refresh_overrun;

  always #5 ck143 = ~ck143;

  sdram_read_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .REFRESH_PERIOD(RP), .TRFC(TR)
  ) dut (
    .ck143(ck143), .reset(reset),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt), .r0_valid(r0_valid), .r0_data(r0_data),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt), .r1_valid(r1_valid), .r1_data(r1_data),
    .cmd_valid(cmd_valid), .cmd_refresh(cmd_refresh), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .refresh_overrun(refresh_overrun)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the job currently owning the engine, plus refresh bookkeeping
  // derived from the number of clock edges since reset.
  typedef enum int {JOB_NONE, JOB_READ, JOB_REF} job_t;
  job_t          m_job;
  int            m_cli;
  logic [AW-1:0] m_addr;
  bit            m_acc;
  int            m_beats;
  int            m_trfc;
  int            m_rr_last;
  bit            m_pending;
  bit            m_overrun;
  int            m_edges;
  bit            m_v[2];
  logic [DW-1:0] m_d[2];

  // Observations
  int gnt_log[$];
  bit saw_gnt[2];
  int v_cnt[2];
  int ref_cnt;
  int gnt_in_trfc;
  int obs_trfc_left;
  bit found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_job = JOB_NONE; m_cli = 0; m_addr = '0; m_acc = 0; m_beats = 0; m_trfc = 0;
    m_rr_last = 1; m_pending = 0; m_overrun = 0; m_edges = 0;
    m_v[0] = 0; m_v[1] = 0; m_d[0] = '0; m_d[1] = '0;
    saw_gnt[0] = 0; saw_gnt[1] = 0; obs_trfc_left = 0;
  endtask

  task automatic step();
    bit            exp_issue, exp_ref, clr;
    logic [AW-1:0] exp_addr;
    @(negedge ck143);
    exp_issue = (m_job == JOB_READ) && !m_acc;
    exp_ref   = (m_job == JOB_REF) && !m_acc;
    exp_addr  = exp_issue ? m_addr : '0;
    chk("cmd_valid", 32'(cmd_valid), 32'(exp_issue || exp_ref));
    chk("cmd_refresh", 32'(cmd_refresh), 32'(exp_ref));
    chk("cmd_addr", 32'(cmd_addr), 32'(exp_addr));
    chk("r0_gnt", 32'(r0_gnt), 32'(exp_issue && cmd_ready && m_cli == 0));
    chk("r1_gnt", 32'(r1_gnt), 32'(exp_issue && cmd_ready && m_cli == 1));
    chk("r0_valid", 32'(r0_valid), 32'(m_v[0]));
    chk("r1_valid", 32'(r1_valid), 32'(m_v[1]));
    chk("r0_data", 32'(r0_data), 32'(m_d[0]));
    chk("r1_data", 32'(r1_data), 32'(m_d[1]));
    chk("busy", 32'(busy), 32'(m_job != JOB_NONE));
    chk("refresh_overrun", 32'(refresh_overrun), 32'(m_overrun));

    if (r0_gnt === 1'b1) begin saw_gnt[0] = 1; gnt_log.push_back(0); end
    if (r1_gnt === 1'b1) begin saw_gnt[1] = 1; gnt_log.push_back(1); end
    if (r0_valid === 1'b1) v_cnt[0]++;
    if (r1_valid === 1'b1) v_cnt[1]++;
    if (obs_trfc_left > 0) begin
      if (r0_gnt === 1'b1 || r1_gnt === 1'b1) gnt_in_trfc++;
      obs_trfc_left--;
    end
    if (cmd_valid === 1'b1 && cmd_refresh === 1'b1 && cmd_ready) begin
      ref_cnt++;
      obs_trfc_left = TR;
    end

    // Advance the model across the coming edge using the inputs now applied.
    clr = 0;
    m_v[0] = 0; m_v[1] = 0;
    case (m_job)
      JOB_NONE: begin
        if (m_pending) begin
          m_job = JOB_REF; m_acc = 0;
        end else if (r0_req || r1_req) begin
          m_cli  = (r0_req && r1_req) ? (1 - m_rr_last) : (r1_req ? 1 : 0);
          m_addr = (m_cli == 1) ? r1_addr : r0_addr;
          m_job  = JOB_READ; m_acc = 0;
        end
      end
      JOB_READ: begin
        if (!m_acc) begin
          if (cmd_ready) begin m_acc = 1; m_rr_last = m_cli; m_beats = 0; end
        end else if (rd_valid) begin
          m_d[m_cli] = rd_data; m_v[m_cli] = 1; m_beats++;
          if (m_beats == BL) m_job = JOB_NONE;
        end
      end
      JOB_REF: begin
        if (!m_acc) begin
          if (cmd_ready) begin m_acc = 1; m_trfc = TR; clr = 1; end
        end else begin
          m_trfc--;
          if (m_trfc == 0) m_job = JOB_NONE;
        end
      end
      default: m_job = JOB_NONE;
    endcase
    m_edges++;
    if ((m_edges % RP) == 0) begin
      if (m_pending) m_overrun = 1;
      m_pending = 1;
    end else if (clr) begin
      m_pending = 0;
    end
    @(posedge ck143);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    r0_req = 0; r1_req = 0; r0_addr = '0; r1_addr = '0;
    cmd_ready = 0; rd_valid = 0; rd_data = '0;
    @(posedge ck143);
    #1;
    chk("rst_cmd_valid", 32'(cmd_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_valids", 32'({r0_valid, r1_valid}), 32'(0));
    chk("rst_overrun", 32'(refresh_overrun), 32'(0));
    reset = 1'b0;
    model_reset();
  endtask

  task automatic drive_random();
    if (saw_gnt[0]) begin r0_req = 0; saw_gnt[0] = 0; end
    if (saw_gnt[1]) begin r1_req = 0; saw_gnt[1] = 0; end
    if (!r0_req && $urandom_range(99) < 30) begin r0_req = 1; r0_addr = AW'($urandom); end
    if (!r1_req && $urandom_range(99) < 30) begin r1_req = 1; r1_addr = AW'($urandom); end
    cmd_ready = ($urandom_range(99) < 70);
    rd_valid  = ($urandom_range(99) < 50);
    rd_data   = DW'($urandom);
  endtask

  initial begin
    model_reset();
    ref_cnt = 0; gnt_in_trfc = 0; v_cnt[0] = 0; v_cnt[1] = 0;

    // 1: single r0 burst
    do_reset();
    r0_req = 1; r0_addr = 24'h000010; cmd_ready = 1;
    step();
    chk("t1_cmd_addr", 32'(cmd_addr), 32'h10);
    gnt_log.delete();
    step();
    r0_req = 0;
    chk("t1_gnt_count", 32'(gnt_log.size()), 32'(1));
    v_cnt[0] = 0; v_cnt[1] = 0;
    rd_valid = 1; rd_data = 16'hAAAA; step();
    chk("t1_first_beat", 32'(r0_data), 32'hAAAA);
    rd_data = 16'hBBBB; step();
    rd_valid = 0; step(); step();
    chk("t1_r0_beats", 32'(v_cnt[0]), 32'(2));
    chk("t1_r1_beats", 32'(v_cnt[1]), 32'(0));
    chk("t1_last_data", 32'(r0_data), 32'hBBBB);

    // 2: both clients held, four bursts alternate starting with r0
    do_reset();
    r0_req = 1; r1_req = 1; r0_addr = AW'($urandom); r1_addr = AW'($urandom);
    cmd_ready = 1; rd_valid = 1;
    gnt_log.delete();
    for (int i = 0; i < 200 && gnt_log.size() < 4; i++) begin
      rd_data = DW'($urandom);
      step();
      if (saw_gnt[0]) begin saw_gnt[0] = 0; r0_addr = AW'($urandom); end
      if (saw_gnt[1]) begin saw_gnt[1] = 0; r1_addr = AW'($urandom); end
    end
    chk("t2_grant_count", 32'(gnt_log.size()), 32'(4));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_grant%0d", i), (gnt_log.size() > i) ? 32'(gnt_log[i]) : 32'hFFFF_FFFF, 32'(i % 2));
    end

    // 3: stalled issue holds the command steady, grant only on accept
    do_reset();
    r1_req = 1; r1_addr = 24'h00ABCD; cmd_ready = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t3_cmd_valid", 32'(cmd_valid), 32'(1));
      chk("t3_cmd_addr", 32'(cmd_addr), 32'h00ABCD);
      chk("t3_no_gnt", 32'({r0_gnt, r1_gnt}), 32'(0));
      step();
    end
    gnt_log.delete();
    cmd_ready = 1;
    step();
    r1_req = 0;
    chk("t3_gnt_once", 32'(gnt_log.size()), 32'(1));
    rd_valid = 1; step(); step(); rd_valid = 0; step();

    // 4: r1 streaming, refresh inserted at first idle after each expiry
    do_reset();
    ref_cnt = 0; gnt_in_trfc = 0;
    r1_req = 1; r1_addr = AW'($urandom); cmd_ready = 1; rd_valid = 1;
    for (int i = 0; i < 120; i++) begin
      rd_data = DW'($urandom);
      step();
      if (saw_gnt[1]) begin saw_gnt[1] = 0; r1_addr = AW'($urandom); end
    end
    chk("t4_refresh_count", 32'(ref_cnt), 32'(2));
    chk("t4_gnt_in_trfc", 32'(gnt_in_trfc), 32'(0));

    // 5: refresh stalled across two expiries -> sticky overrun
    do_reset();
    for (int i = 0; i < 110; i++) step();
    chk("t5_overrun", 32'(refresh_overrun), 32'(1));
    chk("t5_refresh_stuck", 32'(cmd_refresh), 32'(1));
    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end
    chk("t5_overrun_sticky", 32'(refresh_overrun), 32'(1));

    // 6: reset after the first beat of a burst
    cmd_ready = 1; rd_valid = 1;
    if (saw_gnt[0]) begin r0_req = 0; saw_gnt[0] = 0; end
    if (saw_gnt[1]) begin r1_req = 0; saw_gnt[1] = 0; end
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      rd_data = DW'($urandom);
      step();
      if (saw_gnt[0]) begin r0_req = 0; saw_gnt[0] = 0; end
      if (saw_gnt[1]) begin r1_req = 0; saw_gnt[1] = 0; end
      found = !r0_req && !r1_req && (m_job == JOB_NONE);
    end
    chk("t6_drain", 32'(found), 32'(1));
    r0_req = 1; r0_addr = 24'h123456; rd_valid = 0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = saw_gnt[0];
    end
    chk("t6_gnt_seen", 32'(found), 32'(1));
    r0_req = 0; saw_gnt[0] = 0;
    rd_valid = 1; rd_data = 16'h1111;
    step();
    rd_valid = 0;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'({r0_valid, r1_valid}), 32'(0));
    chk("t6_rst_data", 32'(r0_data), 32'(0));
    chk("t6_rst_cmd", 32'({cmd_valid, cmd_refresh}), 32'(0));
    chk("t6_rst_busy", 32'(busy), 32'(0));
    chk("t6_rst_overrun", 32'(refresh_overrun), 32'(0));
    @(posedge ck143);
    #1;
    reset = 1'b0;
    model_reset();
    rd_valid = 1; rd_data = 16'hCCCC;
    step();
    rd_valid = 0;
    chk("t6_late_beat_valid", 32'(r0_valid), 32'(0));
    chk("t6_late_beat_data", 32'(r0_data), 32'(0));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
